// File: rtl/flex_rcv_frame.sv
// flex_rcv_frame: serial frame receiver. It waits for a start edge, checks the start bit
// at mid-bit, samples the data, optional parity and stop bits at mid-bit, then loads the
// payload and its status flags in a one-cycle load state.
module flex_rcv_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned MSB_FIRST    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW   = $clog2(DATA_BITS + 1);

  localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TimerW-1:0] FullLast = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]   CntLast  = CntW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StLoad
  } state_e;

  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 line_prev_q;
  logic                 parity_bit_q, parity_bit_d;
  logic                 stop_bit_q, stop_bit_d;
  logic                 ready_q, ready_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 oe_q, oe_d;

  // Next-state logic for the frame FSM, bit timer, shift register and status flags.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TimerW'(1);
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    parity_bit_d = parity_bit_q;
    stop_bit_d   = stop_bit_q;
    ready_d      = ready_q;
    fe_d         = fe_q;
    pe_d         = pe_q;
    oe_d         = oe_q;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        // line_prev is 0 after reset and after a break, so a held-low line never starts
        if (line_prev_q && !serial_in) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = serial_in ? StIdle : StData;
        end
      end
      StData: begin
        if (timer_q == FullLast) begin
          timer_d = '0;
          cnt_d   = cnt_q + CntW'(1);
          if (MSB_FIRST != 0) begin
            shift_d = {shift_q[DATA_BITS-2:0], serial_in};
          end else begin
            shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
          end
          if (cnt_q == CntLast) begin
            state_d = (PARITY_MODE != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (timer_q == FullLast) begin
          timer_d      = '0;
          parity_bit_d = serial_in;
          state_d      = StStop;
        end
      end
      StStop: begin
        if (timer_q == FullLast) begin
          timer_d    = '0;
          stop_bit_d = serial_in;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        timer_d   = '0;
        state_d   = StIdle;
        rx_data_d = shift_q;
        ready_d   = 1'b1;
        fe_d      = !stop_bit_q;
        pe_d      = (PARITY_MODE != 0) &&
                    ((^shift_q ^ parity_bit_q) != (PARITY_MODE == 2));
        // an acknowledge in the load cycle consumes the old payload, so no overrun
        oe_d      = ready_q && !data_read;
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase

    // Consumer acknowledge; a load in the same cycle takes priority.
    if (state_q != StLoad && data_read && ready_q) begin
      ready_d = 1'b0;
      oe_d    = 1'b0;
    end
  end

  // State registers with asynchronous reset; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      line_prev_q  <= 1'b0;
      parity_bit_q <= 1'b0;
      stop_bit_q   <= 1'b0;
      ready_q      <= 1'b0;
      fe_q         <= 1'b0;
      pe_q         <= 1'b0;
      oe_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      line_prev_q  <= serial_in;
      parity_bit_q <= parity_bit_d;
      stop_bit_q   <= stop_bit_d;
      ready_q      <= ready_d;
      fe_q         <= fe_d;
      pe_q         <= pe_d;
      oe_q         <= oe_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign data_ready    = ready_q;
  assign framing_error = fe_q;
  assign parity_error  = pe_q;
  assign overrun_error = oe_q;

endmodule

// File: tb/tb_flex_rcv_frame.sv
// Bench for flex_rcv_frame: three differently configured receivers, a frame-level reference
// model, and a scoreboard queue drained by a monitor at the expected load/ack cycles.
module tb_flex_rcv_frame;

  localparam int NI = 3;
  // Per-instance configuration: 8N1 LSB-first, 8E1 LSB-first, 9O1 MSB-first.
  localparam int DB  [NI] = '{8, 8, 9};
  localparam int PM  [NI] = '{0, 1, 2};
  localparam int CPB [NI] = '{10, 8, 6};
  localparam int MF  [NI] = '{0, 0, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] si, dr, rdy, fe, pe, oe;
  logic [7:0]    rx0, rx1;
  logic [8:0]    rx2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int inst;
    int due;
    int rx;
    bit rdy;
    bit fe;
    bit pe;
    bit oe;
  } exp_t;

  exp_t sb[$];

  int m_rx  [NI];
  bit m_rdy [NI];
  bit m_fe  [NI];
  bit m_pe  [NI];
  bit m_oe  [NI];

  flex_rcv_frame #(.DATA_BITS(8), .PARITY_MODE(0), .CLKS_PER_BIT(10), .MSB_FIRST(0)) u_dut0 (
    .clk(clk), .rst(rst), .serial_in(si[0]), .data_read(dr[0]), .rx_data(rx0),
    .data_ready(rdy[0]), .framing_error(fe[0]), .parity_error(pe[0]), .overrun_error(oe[0])
  );
  flex_rcv_frame #(.DATA_BITS(8), .PARITY_MODE(1), .CLKS_PER_BIT(8), .MSB_FIRST(0)) u_dut1 (
    .clk(clk), .rst(rst), .serial_in(si[1]), .data_read(dr[1]), .rx_data(rx1),
    .data_ready(rdy[1]), .framing_error(fe[1]), .parity_error(pe[1]), .overrun_error(oe[1])
  );
  flex_rcv_frame #(.DATA_BITS(9), .PARITY_MODE(2), .CLKS_PER_BIT(6), .MSB_FIRST(1)) u_dut2 (
    .clk(clk), .rst(rst), .serial_in(si[2]), .data_read(dr[2]), .rx_data(rx2),
    .data_ready(rdy[2]), .framing_error(fe[2]), .parity_error(pe[2]), .overrun_error(oe[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_rx(input int i);
    case (i)
      0:       return {24'd0, rx0};
      1:       return {24'd0, rx1};
      default: return {23'd0, rx2};
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int due);
    exp_t e;
    e.inst = i;
    e.due  = due;
    e.rx   = m_rx[i];
    e.rdy  = m_rdy[i];
    e.fe   = m_fe[i];
    e.pe   = m_pe[i];
    e.oe   = m_oe[i];
    sb.push_back(e);
  endtask

  // Monitor: compare due scoreboard entries; any data_ready rise not predicted is an error.
  logic [NI-1:0] rdy_prev = '0;
  bit            hit [NI];
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) hit[i] = 0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", e.inst, get_rx(e.inst), e.rx);
        chk("data_ready", e.inst, {31'd0, rdy[e.inst]}, {31'd0, e.rdy});
        chk("framing_error", e.inst, {31'd0, fe[e.inst]}, {31'd0, e.fe});
        chk("parity_error", e.inst, {31'd0, pe[e.inst]}, {31'd0, e.pe});
        chk("overrun_error", e.inst, {31'd0, oe[e.inst]}, {31'd0, e.oe});
        hit[e.inst] = 1;
      end
      for (int i = 0; i < NI; i++) begin
        if (rdy[i] === 1'b1 && rdy_prev[i] !== 1'b1 && !hit[i]) begin
          chk("unexpected_ready_rise", i, 32'd1, 32'd0);
        end
      end
      rdy_prev = rdy;
    end
  end

  // Serialise one frame on instance i; must be called right after a negedge.
  task automatic send_frame(input int i, input int data, input bit pbit, input bit stop,
                            input bit ack_load, input bit low_after);
    int d = DB[i];
    int c = CPB[i];
    int p = (PM[i] != 0) ? 1 : 0;
    int c0;
    int load_n;
    bit bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < d; k++) begin
      if (MF[i] != 0) bits.push_back(bit'((data >> (d - 1 - k)) & 1));
      else            bits.push_back(bit'((data >> k) & 1));
    end
    if (p != 0) bits.push_back(pbit);
    bits.push_back(stop);
    c0 = cyc;
    // Frame-level model: payload value, stop check, parity count, overrun on unread data.
    m_oe[i]  = ack_load ? 1'b0 : m_rdy[i];
    m_rdy[i] = 1'b1;
    m_rx[i]  = data;
    m_fe[i]  = !stop;
    m_pe[i]  = (p != 0) && ((($countones(data) + pbit) % 2) != ((PM[i] == 2) ? 1 : 0));
    // Ready is seen one edge after the load cycle, which itself follows the stop sample.
    push_exp(i, c0 + c / 2 + (d + p + 1) * c + 2);
    load_n = c / 2 + (d + p + 1) * c + 1;
    for (int n = 0; n < bits.size() * c; n++) begin
      si[i] = bits[n / c];
      dr[i] = ack_load && (n == load_n);
      @(negedge clk);
    end
    dr[i] = 1'b0;
    si[i] = !low_after;
  endtask

  task automatic idle(input int i, input int n, input bit lvl);
    si[i] = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input int i);
    if (m_rdy[i]) begin
      m_rdy[i] = 1'b0;
      m_oe[i]  = 1'b0;
    end
    push_exp(i, cyc + 1);
    dr[i] = 1'b1;
    @(negedge clk);
    dr[i] = 1'b0;
  endtask

  task automatic clear_models();
    for (int i = 0; i < NI; i++) begin
      m_rx[i]  = 0;
      m_rdy[i] = 1'b0;
      m_fe[i]  = 1'b0;
      m_pe[i]  = 1'b0;
      m_oe[i]  = 1'b0;
    end
  endtask

  // Start a frame on instance 0, then hit reset 40 cycles in: all outputs must clear at once.
  task automatic reset_mid(input int data);
    int c = CPB[0];
    for (int n = 0; n < 40; n++) begin
      si[0] = (n < c) ? 1'b0 : bit'((data >> ((n - c) / c)) & 1);
      @(negedge clk);
    end
    si = '1;
    #2 rst = 1'b1;
    #1;
    clear_models();
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_rx", i, get_rx(i), 32'd0);
      chk("async_rst_flags", i, {28'd0, rdy[i], fe[i], pe[i], oe[i]}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NI; i++) push_exp(i, cyc + 120);
    idle(0, 125, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int data;
    int ack;
    bit stop;
    clear_models();
    rst = 1'b1;
    si  = '1;
    si[0] = 1'b0;
    dr  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) push_exp(i, cyc + 1);
    rst = 1'b0;
    // Line low at reset release must not be taken as a start.
    idle(0, 120, 1'b0);
    push_exp(0, cyc + 1);
    idle(0, 2, 1'b1);

    // 8N1 0xA5.
    send_frame(0, 'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2, 1'b1);
    do_read(0);

    // Even parity 0x07: wrong then correct parity bit.
    send_frame(1, 'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1, 2, 1'b1);
    do_read(1);
    send_frame(1, 'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 2, 1'b1);
    do_read(1);

    // Break: stop bit 0 and line held low; no new frame until the line returns high.
    send_frame(0, 'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    do_read(0);
    push_exp(0, cyc + 190);
    idle(0, 200, 1'b0);
    idle(0, 3, 1'b1);
    send_frame(0, 'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2, 1'b1);
    do_read(0);

    // Overrun, acknowledge clearing, and acknowledge coincident with load.
    send_frame(0, 'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2, 1'b1);
    send_frame(0, 'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 3, 1'b1);
    do_read(0);
    send_frame(0, 'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 'h44, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(0, 2, 1'b1);
    do_read(0);

    // Glitch shorter than half a bit: false start, nothing changes.
    push_exp(0, cyc + 150);
    idle(0, 3, 1'b0);
    idle(0, 160, 1'b1);

    // MSB-first, odd parity, 9 data bits.
    send_frame(2, 'h0A5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 2, 1'b1);
    do_read(2);

    // Leave a payload pending, then abort a frame with reset.
    send_frame(0, 'h96, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2, 1'b1);
    reset_mid('hC3);

    // Randomised frames on every configuration.
    for (int i = 0; i < NI; i++) begin
      for (int f = 0; f < 15; f++) begin
        data = int'($urandom_range(0, (1 << DB[i]) - 1));
        stop = ($urandom_range(0, 5) != 0);
        ack  = int'($urandom_range(0, 2));
        send_frame(i, data, bit'($urandom_range(0, 1)), stop, ack == 2, 1'b0);
        idle(i, stop ? int'($urandom_range(0, 3)) : 1 + int'($urandom_range(0, 2)), 1'b1);
        if (ack == 1) do_read(i);
      end
      idle(i, 3, 1'b1);
      do_read(i);
    end

    repeat (10) @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 0, sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
